dense_seq_ctrl: RTL
===================

Name: dense_seq_ctrl

Overview:
- Sequencer for the pooling/non-linear dense datapath: splits an input vector of cfg_vec_len elements into chunks of up to 9 and streams each chunk's data/weight pairs into the line and filter buffers.
- Fires the MAC once per chunk and accumulates the partial MAC results across chunks.
- Returns one saturated dot-product per start command.
- Sits between the input/weight fetch logic and the densing datapath; owns every densing control input.

Parameters:
- DATA_W, 16, width of one activation/weight element and of the MAC result.
- ACC_W, 32, signed accumulator/result width.
- LEN_W, 16, width of the vector-length configuration.
- MAC_LAT, 2, cycles from mac_enable to a valid mac_result.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- cfg_vec_len  in  LEN_W  vector length, latched on accepted start
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  activation/weight pair available
- in_ready  out  1  pair accepted when in_valid & in_ready
- in_data  in  DATA_W  activation element
- in_weight  in  DATA_W  weight element
- line_buffer_reset  out  1  clears line buffer before each chunk
- shifting_line  out  1  shift strobe to line buffer
- shifting_filter  out  1  shift strobe to filter buffer
- line_data  out  DATA_W  in_data forwarded (combinational)
- filter_data  out  DATA_W  in_weight forwarded (combinational)
- dense_valid  out  8  number of valid taps in current chunk (0..9)
- mac_enable  out  1  one-cycle MAC fire pulse
- mac_result  in  DATA_W  signed datapath output
- result_valid  out  1  dot-product available
- result_ready  in  1  consumer accepts result
- result_data  out  ACC_W  signed dot-product

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, remaining=0, tap_cnt=0, wait_cnt=0. All outputs 0 except line_data/filter_data, which pass through.
- IDLE: start=1 latches remaining=cfg_vec_len and clears acc.
  - cfg_vec_len=0 goes straight to DONE with result 0.
  - Otherwise goes to CLR.
  - start outside IDLE is ignored.
- CLR (1 cycle): line_buffer_reset=1, tap_cnt=0; chunk=min(9,remaining); go to LOAD.
- LOAD: in_ready=1 while tap_cnt<chunk.
  - Each accepted beat asserts shifting_line=shifting_filter=1 in the same cycle and increments tap_cnt.
  - No strobe when in_valid=0 (stalls allowed on any beat).
  - After the beat making tap_cnt==chunk, go to FIRE.
- FIRE (1 cycle): mac_enable=1, wait_cnt=MAC_LAT; go to WAIT.
- WAIT: decrement wait_cnt each cycle; when it reaches 0, go to ACC.
- ACC (1 cycle): acc = sat_ACC_W(acc + sign_ext(mac_result)); remaining -= chunk.
  - remaining==0 goes to DONE; otherwise go to CLR.
- dense_valid = chunk from CLR through ACC; 0 in IDLE/DONE. Buffers clear between chunks and taps beyond chunk are masked, so a short final chunk contributes no stale products.
- Saturation: positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
- DONE: result_valid=1 and result_data=acc, both held stable until result_ready=1; then go to IDLE in the next cycle (busy drops).
- in_ready is 0 in every state except LOAD; start in the same cycle as a DONE handshake is ignored.
- Latency for an unstalled single chunk of n taps, counted from start to result_valid: 1 (CLR) + n + 1 (FIRE) + MAC_LAT + 1 (ACC) + 1 cycles.
- Reset mid-operation drops the partial result; no result_valid is produced.

Test Plan:
- cfg_vec_len=9, data 1..9, weights all 1, mac_result model returns tap sum → one CLR, 9 shift strobes, one mac_enable, dense_valid=9, result_data=45.
- cfg_vec_len=20, all data 2, weights 3 → chunks 9/9/2 with dense_valid 9,9,2, three line_buffer_reset pulses, result_data=120.
- cfg_vec_len=0 → result_valid one cycle after start, result_data=0, no strobes, no mac_enable.
- in_valid toggled 1/0 every cycle with cfg_vec_len=5 → exactly 5 shifting_line pulses, each only on in_valid&in_ready cycles; result correct.
- Accumulator preset so partial sums exceed 2^31-1 (ACC_W=32) → result_data=32'h7FFFFFFF; result_ready held 0 for 10 cycles → data stable, busy=1.
- rst asserted during WAIT of chunk 2 → all outputs 0 immediately; a new start with cfg_vec_len=3 completes correctly.

Source files
------------

// File: rtl/dense_seq_ctrl.sv
// Dense-datapath sequencer: streams a vector through the line/filter buffers in
// chunks of up to 9 taps, fires the MAC per chunk and accumulates a saturated dot-product.
module dense_seq_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int LEN_W   = 16,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_vec_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    output logic              line_buffer_reset,
    output logic              shifting_line,
    output logic              shifting_filter,
    output logic [DATA_W-1:0] line_data,
    output logic [DATA_W-1:0] filter_data,
    output logic [7:0]        dense_valid,
    output logic              mac_enable,
    input  logic [DATA_W-1:0] mac_result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result_data,
    output logic [2:0]        dbg_state
);
    // Handshakes: in_* and result_* transfer on a cycle where valid and ready are both high;
    // valid never depends on ready, and result_valid/result_data hold until accepted.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_FIRE = 3'd3,
        S_WAIT = 3'd4,
        S_ACC  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    localparam int         WAIT_W    = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [3:0] MAX_CHUNK = 4'd9;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [3:0]          chunk_q, chunk_d;
    logic [3:0]          tap_cnt_q, tap_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [3:0]          chunk_calc;
    logic [ACC_W:0]      sum_ext;
    logic [ACC_W-1:0]    acc_sat;

    assign chunk_calc = (remaining_q >= LEN_W'(MAX_CHUNK)) ? MAX_CHUNK : remaining_q[3:0];

    // One guard bit exposes signed overflow: the top two bits disagree only on wrap.
    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W + 1 - DATA_W){mac_result[DATA_W-1]}}, mac_result};
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_sat = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
            chunk_q     <= '0;
            tap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            chunk_q     <= chunk_d;
            tap_cnt_q   <= tap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        acc_d             = acc_q;
        remaining_d       = remaining_q;
        chunk_d           = chunk_q;
        tap_cnt_d         = tap_cnt_q;
        wait_cnt_d        = wait_cnt_q;
        busy              = 1'b1;
        in_ready          = 1'b0;
        line_buffer_reset = 1'b0;
        shifting_line     = 1'b0;
        shifting_filter   = 1'b0;
        dense_valid       = 8'd0;
        mac_enable        = 1'b0;
        result_valid      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    remaining_d = cfg_vec_len;
                    acc_d       = '0;
                    state_d     = (cfg_vec_len == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                line_buffer_reset = 1'b1;
                tap_cnt_d         = '0;
                chunk_d           = chunk_calc;
                dense_valid       = {4'd0, chunk_calc};
                state_d           = S_LOAD;
            end
            S_LOAD: begin
                dense_valid = {4'd0, chunk_q};
                in_ready    = (tap_cnt_q < chunk_q);
                if (in_valid && in_ready) begin
                    shifting_line   = 1'b1;
                    shifting_filter = 1'b1;
                    tap_cnt_d       = tap_cnt_q + 4'd1;
                    if (tap_cnt_q + 4'd1 == chunk_q) begin
                        state_d = S_FIRE;
                    end
                end
            end
            S_FIRE: begin
                dense_valid = {4'd0, chunk_q};
                mac_enable  = 1'b1;
                wait_cnt_d  = WAIT_W'(MAC_LAT);
                state_d     = (MAC_LAT == 0) ? S_ACC : S_WAIT;
            end
            S_WAIT: begin
                dense_valid = {4'd0, chunk_q};
                wait_cnt_d  = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q <= WAIT_W'(1)) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                dense_valid = {4'd0, chunk_q};
                acc_d       = acc_sat;
                remaining_d = remaining_q - LEN_W'(chunk_q);
                state_d     = (remaining_d == '0) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign line_data   = in_data;
    assign filter_data = in_weight;
    assign result_data = acc_q;
    assign dbg_state   = state_q;

endmodule
